// File: rtl/ahb_split_ctrl.sv
// ahb_split_ctrl: slave-side AHB SPLIT controller for a shared, sometimes-busy
// resource. Unlocked transfers that hit a busy resource get a two-cycle SPLIT
// and the master is parked in a pending mask. Once the resource is free,
// pending masters are released one at a time, round-robin, with a
// one-cycle HSPLITx pulse. Illegal HMASTER values get a two-cycle ERROR.
// Locked transfers that hit a busy resource wait in place.
//
// Optional feature macro: AHB_SPLIT_TIMEOUT_EN
//   defined   -> a locked wait gives up after WAIT_MAX wait states with ERROR
//   undefined -> a locked wait holds until the resource is free (no counter)

// One master's pending bit and its release pulse. A set on the same cycle
// as a release wins: the bit stays pending and no pulse is produced.
module ahb_split_pend_cell (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic set,
  input  logic rel,
  output logic pend,
  output logic pulse
);

  // pending bit and one-cycle release pulse
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= rel & ~set;
      if (set)      pend <= 1'b1;
      else if (rel) pend <= 1'b0;
    end
  end

endmodule

module ahb_split_ctrl #(
  parameter int NUM_MASTERS = 16,
  parameter int RELEASE_GAP = 2,
  parameter int WAIT_MAX    = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  input  logic        res_busy,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLITx,
  output logic [15:0] pending
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SPL1 = 3'd1;
  localparam logic [2:0] S_SPL2 = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_ERR1 = 3'd4;
  localparam logic [2:0] S_ERR2 = 3'd5;

  localparam logic [1:0] R_OKAY  = 2'b00;
  localparam logic [1:0] R_ERROR = 2'b01;
  localparam logic [1:0] R_SPLIT = 2'b11;

  localparam logic [4:0] NM    = 5'(NUM_MASTERS);
  localparam logic [3:0] NM_M1 = 4'(NUM_MASTERS - 1);
  localparam logic [3:0] GAP   = 4'(RELEASE_GAP);

  logic [2:0]  state, nxt;
  logic        accept, bad_mst, go_split;
  logic [15:0] set16, rel16;
  logic [3:0]  ptr, gap, sel;
  logic [4:0]  idx;
  logic        found, sched_en, fire;

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign bad_mst = ({1'b0, HMASTER} >= NM);

`ifdef AHB_SPLIT_TIMEOUT_EN
  localparam logic [7:0] WMAX_M1 = 8'(WAIT_MAX - 1);
  logic [7:0] wcnt;

  // wait-state count for the current locked wait; cleared outside WAIT
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)             wcnt <= '0;
    else if (state != S_WAIT) wcnt <= '0;
    else                      wcnt <= wcnt + 8'd1;
  end
`else
  localparam int unused_wait_max = WAIT_MAX;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, HTRANS[0]};

  // response FSM: states with HREADYOUT=1 may take a new address phase
  always_comb begin
    nxt      = state;
    go_split = 1'b0;
    case (state)
      S_IDLE, S_SPL2, S_ERR2: begin
        nxt = S_IDLE;
        if (accept) begin
          if (bad_mst)        nxt = S_ERR1;
          else if (res_busy) begin
            if (HMASTLOCK)    nxt = S_WAIT;
            else begin
              nxt      = S_SPL1;
              go_split = 1'b1;
            end
          end
        end
      end
      S_SPL1: nxt = S_SPL2;
      S_ERR1: nxt = S_ERR2;
      S_WAIT: begin
        if (!res_busy)           nxt = S_IDLE;
`ifdef AHB_SPLIT_TIMEOUT_EN
        else if (wcnt == WMAX_M1) nxt = S_ERR1;
`endif
      end
      default: nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_IDLE;
    else          state <= nxt;
  end

  // data-phase response decoded from state so reset shows up immediately
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = R_OKAY;
    case (state)
      S_SPL1: begin HREADYOUT = 1'b0; HRESP = R_SPLIT; end
      S_SPL2: begin HREADYOUT = 1'b1; HRESP = R_SPLIT; end
      S_WAIT: begin HREADYOUT = 1'b0; HRESP = R_OKAY;  end
      S_ERR1: begin HREADYOUT = 1'b0; HRESP = R_ERROR; end
      S_ERR2: begin HREADYOUT = 1'b1; HRESP = R_ERROR; end
      default: begin HREADYOUT = 1'b1; HRESP = R_OKAY; end
    endcase
  end

  // one-hot pending set for the master being split this cycle
  always_comb begin
    set16 = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      set16[i] = go_split && (HMASTER == 4'(i));
  end

  // round-robin search: first pending bit at or after ptr, wrapping at N-1
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= NM) idx = idx - NM;
      if (!found && pending[idx[3:0]]) begin
        found = 1'b1;
        sel   = idx[3:0];
      end
    end
  end

  // no releases while the resource is busy, during a SPLIT response,
  // or while the inter-pulse gap is still running
  assign sched_en = ~res_busy & (|pending) & (gap == 4'd0) &
                    (state != S_SPL1) & (state != S_SPL2);
  assign fire     = sched_en & found & ~set16[sel];

  // one-hot release request to the selected master
  always_comb begin
    rel16 = '0;
    if (fire) rel16[sel] = 1'b1;
  end

  // release pointer and gap counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr <= '0;
      gap <= '0;
    end else if (fire) begin
      ptr <= (sel == NM_M1) ? 4'd0 : sel + 4'd1;
      gap <= GAP;
    end else if (gap != 4'd0) begin
      gap <= gap - 4'd1;
    end
  end

  // per-master pending/pulse cells; lanes above NUM_MASTERS are tied off
  for (genvar g = 0; g < 16; g++) begin : g_lane
    if (g < NUM_MASTERS) begin : g_on
      ahb_split_pend_cell u_cell (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .set    (set16[g]),
        .rel    (rel16[g]),
        .pend   (pending[g]),
        .pulse  (HSPLITx[g])
      );
    end else begin : g_off
      assign pending[g] = 1'b0;
      assign HSPLITx[g] = 1'b0;
    end
  end

endmodule
